// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receiver (data width, parity, stop bits) with per-word parity/framing flags; define UART_RX_MAJORITY_EN for 2-of-3 majority sampling
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rxd,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DLAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] SLAST = IW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic perr_lat_q, perr_lat_d, ferr_lat_q, ferr_lat_d;
  logic parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic data_valid_q, data_valid_d;
  logic rx_s, samp, sample_now, par_x;
  assign rx_s = sync_q[1];
  assign sync_d = {sync_q[0], uart_rxd};
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  logic [2:0] win;
  assign hist_d = {hist_q[0], rx_s};
  assign win = {hist_q, rx_s};
  assign samp = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
  // history of the synchronised line for the majority vote
  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b11;
    else hist_q <= hist_d;
  end
`else
  assign samp = rx_s;
`endif
  // state register and all datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      perr_lat_q   <= 1'b0;
      ferr_lat_q   <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      perr_lat_q   <= perr_lat_d;
      ferr_lat_q   <= ferr_lat_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      data_valid_q <= data_valid_d;
    end
  end
  // next-state, bit-period counter and bit index
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : START;
      end
      START: if (cnt_q == HALF) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = samp ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == DLAST) ? '0 : idx_q + IW'(1);
        state_d = (idx_q != DLAST) ? DATA : (PARITY_MODE != 0) ? PARITY : STOP;
      end
      PARITY: if (cnt_q == LAST) begin
        cnt_d = '0;
        state_d = STOP;
      end
      STOP: if (cnt_q == LAST) begin
        cnt_d = '0;
        idx_d = (idx_q == SLAST) ? '0 : idx_q + IW'(1);
        state_d = (idx_q == SLAST) ? DONE : STOP;
      end
      DONE: begin
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // shift register, error latches and output registers loaded in DONE
  always_comb begin
    sample_now = cnt_q == LAST;
    par_x = ^shift_q ^ samp;
    shift_d = (state_q == DATA && sample_now) ? {samp, shift_q[DATA_BITS-1:1]} : shift_q;
    perr_lat_d = (state_q == IDLE) ? 1'b0 : (state_q == PARITY && sample_now) ? ((PARITY_MODE == 1) ? ~par_x : par_x) : perr_lat_q;
    ferr_lat_d = (state_q == IDLE) ? 1'b0 : (state_q == STOP && sample_now && !samp) ? 1'b1 : ferr_lat_q;
    data_d = (state_q == DONE) ? shift_q : data_q;
    parity_err_d = (state_q == DONE) ? perr_lat_q : parity_err_q;
    frame_err_d = (state_q == DONE) ? ferr_lat_q : frame_err_q;
    data_valid_d = state_q == DONE;
  end
  assign busy = state_q != IDLE;
  assign data_valid = data_valid_q;
  assign data = data_q;
  assign parity_err = parity_err_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed vectors for 8N1, 8E1 and 7N2 receivers plus glitch, reset and spike sequences
module tb_uart_rx_framed;
  localparam int C = 16;
  localparam int SPK = (C - 1) / 2 + 1;
  typedef struct {
    int sel;
    logic [8:0] word;
    logic pb;
    logic [1:0] st;
    logic [8:0] ed;
    logic ep;
    logic ef;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rxd = 3'b111;
  logic [2:0] dv, pe, fe, bz;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] dat [3];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int start_cyc = 0;
  int nstb [3] = '{0, 0, 0};
  int stb_cyc [3] = '{0, 0, 0};
  logic [8:0] cap_d [3];
  logic cap_p [3];
  logic cap_f [3];
  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {2'b00, d2};
  uart_rx_framed #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[0]), .data_valid(dv[0]), .data(d0),
    .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));
  uart_rx_framed #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[1]), .data_valid(dv[1]), .data(d1),
    .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));
  uart_rx_framed #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .uart_rxd(rxd[2]), .data_valid(dv[2]), .data(d2),
    .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (dv[i]) begin
      nstb[i] <= nstb[i] + 1;
      cap_d[i] <= dat[i];
      cap_p[i] <= pe[i];
      cap_f[i] <= fe[i];
      stb_cyc[i] <= cyc;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic send(input int s, input logic [8:0] w, input logic pb, input logic [1:0] st, input int spike);
    int nb = (s == 2) ? 7 : 8;
    int ns = (s == 2) ? 2 : 1;
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) q.push_back(w[i]);
    if (s == 1) q.push_back(pb);
    for (int i = 0; i < ns; i++) q.push_back(st[i]);
    foreach (q[j]) for (int k = 0; k < C; k++) begin
      rxd[s] = (j == spike && k == SPK) ? 1'b1 : q[j];
      if (j == 0 && k == 0) start_cyc = cyc;
      @(posedge clk);
      #1;
    end
    rxd[s] = 1'b1;
  endtask
  initial begin
    vec_t v [10];
    int s, n0;
    logic [8:0] spike_exp;
    v[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    v[1] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
    v[2] = '{0, 9'h0FF, 1'b0, 2'b10, 9'h0FF, 1'b0, 1'b1};
    v[3] = '{1, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
    v[4] = '{1, 9'h03C, 1'b1, 2'b11, 9'h03C, 1'b1, 1'b0};
    v[5] = '{1, 9'h001, 1'b1, 2'b11, 9'h001, 1'b0, 1'b0};
    v[6] = '{1, 9'h001, 1'b0, 2'b11, 9'h001, 1'b1, 1'b0};
    v[7] = '{2, 9'h055, 1'b0, 2'b01, 9'h055, 1'b0, 1'b1};
    v[8] = '{2, 9'h012, 1'b0, 2'b11, 9'h012, 1'b0, 1'b0};
    v[9] = '{2, 9'h07F, 1'b0, 2'b10, 9'h07F, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_valid", dv[i], 0);
      chk("rst_data", dat[i], 0);
      chk("rst_perr", pe[i], 0);
      chk("rst_ferr", fe[i], 0);
      chk("rst_busy", bz[i], 0);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      s = v[i].sel;
      n0 = nstb[s];
      send(s, v[i].word, v[i].pb, v[i].st, -1);
      repeat (C + 4) @(posedge clk);
      #1;
      chk("strobes", nstb[s] - n0, 1);
      chk("data", cap_d[s], v[i].ed);
      chk("perr", cap_p[s], v[i].ep);
      chk("ferr", cap_f[s], v[i].ef);
      chk("idle_busy", bz[s], 0);
      if (i == 0) chk("latency", stb_cyc[0] - start_cyc - 1, 155);
    end
    n0 = nstb[0];
    rxd[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rxd[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("glitch_busy_hi", bz[0], 1);
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("glitch_busy_lo", bz[0], 0);
      repeat (50) @(posedge clk);
      #1;
    end
    chk("glitch_strobes", nstb[0] - n0, 0);
    n0 = nstb[0];
    fork
      send(0, 9'h0F0, 1'b0, 2'b11, -1);
      begin
        repeat (5 * C + 8) @(posedge clk);
        #1;
        chk("midframe_busy", bz[0], 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_valid", dv[0], 0);
        chk("abort_data", dat[0], 0);
        chk("abort_perr", pe[0], 0);
        chk("abort_ferr", fe[0], 0);
        chk("abort_busy", bz[0], 0);
      end
    join
    repeat (C + 4) @(posedge clk);
    #1;
    chk("abort_strobes", nstb[0] - n0, 0);
    n0 = nstb[0];
    send(0, 9'h0C3, 1'b0, 2'b11, -1);
    repeat (C + 4) @(posedge clk);
    #1;
    chk("post_rst_strobes", nstb[0] - n0, 1);
    chk("post_rst_data", cap_d[0], 9'h0C3);
    chk("post_rst_perr", cap_p[0], 0);
    chk("post_rst_ferr", cap_f[0], 0);
`ifdef UART_RX_MAJORITY_EN
    spike_exp = 9'h000;
`else
    spike_exp = 9'h008;
`endif
    n0 = nstb[0];
    send(0, 9'h000, 1'b0, 2'b11, 4);
    repeat (C + 4) @(posedge clk);
    #1;
    chk("spike_strobes", nstb[0] - n0, 1);
    chk("spike_data", cap_d[0], spike_exp);
    chk("spike_ferr", cap_f[0], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
